qadd_seq: RTL and testbench
===========================

# qadd_seq

Operand sequencer and result collector for the `qadd` three-stage pipeline (c = a + 2b, modulo 2^SIZE).
- Accepts operand pairs on a valid/ready input port and buffers them in a small FIFO.
- Issues one pair at a time to `qadd` with a one-cycle `start` pulse, and holds `a`/`b` stable for the whole pipeline latency, because `qadd` stages 2–3 and `ok` read `b`/`a` live.
- Captures `c`/`ok` and presents them on a valid/ready output port.
- Sits directly upstream and downstream of `qadd`, and shares its clock and reset.

## Interface
Parameters:
- `SIZE`, 8, operand/result width (must match `qadd`)
- `DEPTH`, 4, input FIFO entries (power of two, ≥2)
- `LAT`, 3, `qadd` latency in clock edges from the `start` cycle to `c` valid

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset; the same net drives `qadd.rst`
- `in_valid` in 1: operand pair offered
- `in_ready` out 1: FIFO can accept
- `in_a` in SIZE: operand a
- `in_b` in SIZE: operand b
- `q_start` out 1: to `qadd.start`
- `q_a` out SIZE: to `qadd.a`
- `q_b` out SIZE: to `qadd.b`
- `q_c` in SIZE: from `qadd.c`
- `q_ok` in 1: from `qadd.ok`
- `out_valid` out 1: result held
- `out_ready` in 1: consumer accepts
- `out_c` out SIZE: captured result
- `out_ok` out 1: captured `ok` flag

## Operation
- Input push: occurs when `in_valid && in_ready`.
  - `in_ready = !full && !rst`.
  - No same-cycle bypass when full.
  - Simultaneous push and pop leaves the count unchanged.
- Operand registers: `op_a`/`op_b` drive `q_a`/`q_b`.
  - Loaded from the FIFO head, with a pop, only on a transition into ISSUE.
  - Held unchanged otherwise, including in IDLE and DONE.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, DONE.
  - IDLE: FIFO non-empty → load op regs, pop, go to ISSUE. Otherwise stay.
  - ISSUE: `q_start=1` for exactly this cycle. Clear the wait counter. Go to WAIT.
  - WAIT: stay for LAT-1 cycles (2 by default), then go to CAPTURE.
  - CAPTURE: `q_c` is valid this cycle. Register `out_c<=q_c` and `out_ok<=q_ok`. Go to DONE.
  - DONE: `out_valid=1`.
    - If `out_ready` and the FIFO is non-empty: load op regs, pop, go to ISSUE.
    - If `out_ready` and the FIFO is empty: go to IDLE.
    - If `!out_ready`: stay, with `out_c`/`out_ok` stable.
- Arithmetic: performed entirely inside `qadd`; this block does no computation.
  - Results wrap modulo 2^SIZE.
  - `out_ok` is passed through unmodified, so it is 0 when the result is 0.
- `q_start` is 0 in every state except ISSUE.

## Timing
- Reset values (any cycle with `rst=1`): state IDLE, FIFO empty, `in_ready=0`, `q_start=0`, `q_a=0`, `q_b=0`, `out_valid=0`, `out_c=0`, `out_ok=0`.
- Reset mid-operation: all in-flight and buffered operands are dropped, and no result is emitted.
- Pipeline timing with ISSUE in cycle 0:
  - `qadd` st1=A after edge 0, st2=A+B after edge 1, st3=A+2B after edge 2.
  - CAPTURE in cycle 3.
  - `out_valid` rises in cycle 4.
- End-to-end latency, idle block with empty FIFO:
  - Input handshake in cycle h.
  - IDLE sees the entry in h+1.
  - ISSUE in h+2.
  - `out_valid` in h+6.
- Throughput: one result per 5 cycles with `out_ready` held high.
- Back-to-back: DONE→ISSUE directly, with no IDLE cycle.
- Backpressure: `out_ready` low stalls the FSM in DONE.
  - The FIFO keeps filling until full.
  - DEPTH+1 pairs are accepted in total (one in the op regs, DEPTH in the FIFO).

## Structure
- Shared package `qadd_pkg`: `SIZE` and `LAT` constants, and the `qadd_seq_state_t` enum (IDLE, ISSUE, WAIT, CAPTURE, DONE).
- One sub-module: `qadd_fifo`, a synchronous FIFO of width 2·SIZE and depth DEPTH.
  - Ports: `push`, `pop`, `full`, `empty`, `head`.
  - Empty after `rst`.
- The wait counter and FSM live in `qadd_seq`.
- The bench and top level instantiate `qadd_seq` alongside `qadd`.

## Test plan
- Single op, a=5, b=3, `out_ready=1` → `out_c=11`, `out_ok=1`; `out_valid` rises exactly 6 cycles after the handshake; `q_start` is high for exactly 1 cycle.
- Wrap-around, a=200, b=40 → `out_c=24`, `out_ok=1`.
- Zero result, a=0, b=0 → `out_c=0`, `out_ok=0`; the block still completes the handshake and returns to IDLE.
- Backpressure: hold `out_ready=0` and offer 6 pairs (1,1)..(6,6) →
  - exactly 5 are accepted, and `in_ready` drops after the 5th;
  - `out_c=3` holds stable;
  - on release, results 3, 6, 9, 12, 15 appear in order, 5 cycles apart.
- Back-to-back stream of 3 pairs with `out_ready=1` → no IDLE between ops; `q_a`/`q_b` stay constant from ISSUE through CAPTURE of each op.
- Reset mid-op: assert `rst` for 1 cycle while in WAIT with 2 entries queued →
  - all outputs are at reset values the next cycle;
  - no result emerges;
  - a new pair a=1, b=2 afterwards yields `out_c=5`.

Source files
------------

// File: rtl/qadd_pkg.sv
// Shared constants and FSM encoding for the qadd pipeline and its sequencer.
package qadd_pkg;
  localparam int SIZE = 8;
  localparam int LAT  = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DONE
  } qadd_seq_state_t;
endpackage

// File: rtl/qadd_fifo.sv
// Synchronous FIFO holding queued operand pairs; head is the oldest entry.
// Pushes when full and pops when empty are ignored.
module qadd_fifo import qadd_pkg::*; #(
  parameter int W     = 2 * qadd_pkg::SIZE,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/qadd_seq.sv
// Feeds queued operand pairs to qadd one at a time, holding a/b through the
// pipeline, and presents each captured c/ok on a valid/ready output port.
module qadd_seq import qadd_pkg::*; #(
  parameter int SIZE  = qadd_pkg::SIZE,
  parameter int DEPTH = 4,
  parameter int LAT   = qadd_pkg::LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_a,
  input  logic [SIZE-1:0] in_b,
  output logic            q_start,
  output logic [SIZE-1:0] q_a,
  output logic [SIZE-1:0] q_b,
  input  logic [SIZE-1:0] q_c,
  input  logic            q_ok,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_c,
  output logic            out_ok
);
  localparam int CW = (LAT > 2) ? $clog2(LAT) : 1;

  qadd_seq_state_t state, nxt;
  logic [CW-1:0]     cnt;
  logic [SIZE-1:0]   op_a, op_b, c_reg;
  logic              ok_reg;
  logic              fifo_full, fifo_empty, push, load;
  logic [2*SIZE-1:0] fifo_head;

  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;

  qadd_fifo #(.W(2*SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (load),
    .din   ({in_a, in_b}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    load = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load = 1'b1;
          nxt  = ISSUE;
        end
      end
      ISSUE:   nxt = WAIT;
      WAIT:    if (cnt == CW'(LAT - 2)) nxt = CAPTURE;
      CAPTURE: nxt = DONE;
      DONE: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            load = 1'b1;
            nxt  = ISSUE;
          end else begin
            nxt = IDLE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Counts WAIT cycles; qadd's result is ready LAT edges after ISSUE.
  always_ff @(posedge clk) begin
    if (rst || state == ISSUE) cnt <= '0;
    else if (state == WAIT)    cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
    end else if (load) begin
      {op_a, op_b} <= fifo_head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_reg  <= '0;
      ok_reg <= 1'b0;
    end else if (state == CAPTURE) begin
      c_reg  <= q_c;
      ok_reg <= q_ok;
    end
  end

  // Outputs read as reset values during any cycle with rst high.
  assign q_start   = (state == ISSUE) && !rst;
  assign out_valid = (state == DONE) && !rst;
  assign q_a       = rst ? '0 : op_a;
  assign q_b       = rst ? '0 : op_b;
  assign out_c     = rst ? '0 : c_reg;
  assign out_ok    = rst ? 1'b0 : ok_reg;
endmodule

// File: tb/tb_qadd_seq.sv
// Bench for qadd_seq driving a behavioural qadd pipeline; results are scored
// against c = (a + 2b) mod 2^SIZE, ok = (c != 0).
module tb_qadd_seq;
  localparam int SIZE  = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid, in_ready, q_start, q_ok, out_valid, out_ready, out_ok;
  logic [SIZE-1:0] in_a, in_b, q_a, q_b, q_c, out_c;

  always #5 clk = ~clk;

  qadd_seq #(.SIZE(SIZE), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .q_start(q_start), .q_a(q_a), .q_b(q_b), .q_c(q_c), .q_ok(q_ok),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_ok(out_ok)
  );

  // qadd stand-in: st1 = a at start, then two stages each adding the live b.
  logic [SIZE-1:0] st1, st2, st3;
  always @(posedge clk) begin
    if (rst) begin
      st1 <= '0; st2 <= '0; st3 <= '0;
    end else begin
      if (q_start) st1 <= q_a;
      st2 <= st1 + q_b;
      st3 <= st2 + q_b;
    end
  end
  assign q_c  = st3;
  assign q_ok = (st3 != '0);

  typedef struct {
    int c;
    int ok;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   pop_cyc[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, hs_cyc = 0, pop_cnt = 0, qs_cnt = 0;
  int   hold = 0, q0, pc, acc_cnt, n, ra, rb;
  int   ha, hb;
  bit   acc, rand_done;

  function automatic exp_t ref_model(input int a, input int b);
    exp_t r;
    r.c  = (a + 2 * b) % (1 << SIZE);
    r.ok = (r.c != 0) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: score every accepted result against the queued expectation.
  always @(negedge clk) begin
    if (!rst && q_start) qs_cnt++;
    if (!rst && out_valid && out_ready) begin
      pop_cnt++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_c", int'(out_c), mon_e.c);
        chk("out_ok", int'(out_ok), mon_e.ok);
      end
    end
  end

  // Operands must not move from ISSUE through CAPTURE.
  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
    end else if (q_start) begin
      ha = int'(q_a); hb = int'(q_b); hold = LAT;
    end else if (hold > 0) begin
      chk("op_a_stable", int'(q_a), ha);
      chk("op_b_stable", int'(q_b), hb);
      hold--;
    end
  end

  // Called and returns at 1 time unit after a rising edge.
  task automatic push(input int a, input int b, input int max_wait, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = a[SIZE-1:0];
    in_b = b[SIZE-1:0];
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        hs_cyc = cyc;
        exp_q.push_back(ref_model(a, b));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int max);
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < max) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag, input int exp_in_ready);
    chk({tag, "_in_ready"}, int'(in_ready), exp_in_ready);
    chk({tag, "_q_start"}, int'(q_start), 0);
    chk({tag, "_q_a"}, int'(q_a), 0);
    chk({tag, "_q_b"}, int'(q_b), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_c"}, int'(out_c), 0);
    chk({tag, "_out_ok"}, int'(out_ok), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset", 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single op: latency and single start pulse.
    q0 = qs_cnt;
    push(5, 3, 10, acc);
    chk("t1_accept", int'(acc), 1);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk("t1_latency", cyc - hs_cyc, 6);
    @(posedge clk); #1;
    drain("t1_drain", 20);
    chk("t1_start_pulses", qs_cnt - q0, 1);

    // Wrap-around and zero result.
    push(200, 40, 10, acc);
    drain("t2_drain", 20);
    push(0, 0, 10, acc);
    drain("t3_drain", 20);
    @(negedge clk);
    chk("t3_idle_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;

    // Backpressure: DEPTH+1 accepted, result held stable.
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      push(k, k, 20, acc);
      acc_cnt += int'(acc);
    end
    @(negedge clk);
    chk("bp_in_ready_low", int'(in_ready), 0);
    @(posedge clk); #1;
    push(6, 6, 10, acc);
    chk("bp_accepted", acc_cnt + int'(acc), 5);
    pop_cyc.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_c", int'(out_c), 3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("bp_drain", 80);
    chk("bp_pops", pop_cyc.size(), 5);
    for (int k = 1; k < pop_cyc.size(); k++) chk("bp_spacing", pop_cyc[k] - pop_cyc[k-1], 5);

    // Back-to-back stream.
    pop_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      ra = $urandom_range(0, 255); rb = $urandom_range(0, 255);
      push(ra, rb, 10, acc);
    end
    drain("b2b_drain", 60);
    chk("b2b_pops", pop_cyc.size(), 3);
    for (int k = 1; k < pop_cyc.size(); k++) chk("b2b_spacing", pop_cyc[k] - pop_cyc[k-1], 5);

    // Reset while in WAIT with two entries queued.
    push(10, 10, 10, acc);
    push(20, 20, 10, acc);
    push(30, 30, 10, acc);
    rst = 1'b1;
    exp_q.delete();
    pc = pop_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst", 1);
    @(posedge clk); #1;
    repeat (15) begin @(posedge clk); #1; end
    chk("midrst_no_result", pop_cnt - pc, 0);
    push(1, 2, 10, acc);
    drain("midrst_new_op", 20);

    // Randomized operands with random consumer backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          ra = $urandom_range(0, 255); rb = $urandom_range(0, 255);
          push(ra, rb, 300, acc);
          chk("rand_accept", int'(acc), 1);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 1) == 1);
        end
        out_ready = 1'b1;
      end
    join
    drain("rand_drain", 600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
